arm_mc_mainfsm: RTL and testbench

- Moore main-control state machine of the multicycle ARM datapath.
- Sits directly upstream of the register file: sequences fetch, decode, execute, memory and writeback steps.
- Drives register-file write enable `regw` (qualified by condition logic into `we3`), memory write, IR/PC enables and the datapath mux selects.
- Counts retired instructions for debug.

---
 rtl/arm_mc_mainfsm_if.sv | 36 +++
 rtl/arm_mc_mainfsm.sv | 190 +++++++++++++++++++
 tb/tb_arm_mc_mainfsm.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/arm_mc_mainfsm_if.sv
// Control bundle between the multicycle ARM main FSM and its datapath.
// master: the FSM (consumes decode fields, drives controls).
// slave : the datapath side (drives decode fields, consumes controls).
interface arm_mc_mainfsm_if #(
  parameter int INSTR_CNT_W = 32
) ();

  logic [1:0]             op;
  logic [5:0]             funct;
  logic                   mem_ready;
  logic                   irwrite;
  logic                   nextpc;
  logic                   regw;
  logic                   memw;
  logic                   branch;
  logic                   aluop;
  logic                   adrsrc;
  logic [1:0]             alusrca;
  logic [1:0]             alusrcb;
  logic [1:0]             resultsrc;
  logic [3:0]             state;
  logic [INSTR_CNT_W-1:0] retired;

  modport master (
    input  op, funct, mem_ready,
    output irwrite, nextpc, regw, memw, branch, aluop, adrsrc,
           alusrca, alusrcb, resultsrc, state, retired
  );

  modport slave (
    output op, funct, mem_ready,
    input  irwrite, nextpc, regw, memw, branch, aluop, adrsrc,
           alusrca, alusrcb, resultsrc, state, retired
  );

endinterface

// File: rtl/arm_mc_mainfsm.sv
// Moore main-control FSM of the multicycle ARM datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retired
// instructions. Optional macro ARM_MC_MEM_WAIT_EN makes FETCH, MEMREAD and
// MEMWRITE wait for mem_ready and gates irwrite/nextpc/memw with it.
module arm_mc_mainfsm #(
  parameter int INSTR_CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  arm_mc_mainfsm_if.master    bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTR_CNT_W-1:0] retired_q, retired_d;
  logic                   retire_s;
  logic                   mem_ok_s;

  logic                   irwrite_s, nextpc_s, regw_s, memw_s, branch_s;
  logic                   aluop_s, adrsrc_s;
  logic [1:0]             alusrca_s, alusrcb_s, resultsrc_s;

`ifdef ARM_MC_MEM_WAIT_EN
  assign mem_ok_s = bus.mem_ready;
`else
  // Without the wait feature memory is always ready; mem_ready is ignored.
  logic mem_ready_unused_s;
  assign mem_ready_unused_s = bus.mem_ready;
  assign mem_ok_s = 1'b1;
`endif

  // Next-state selection and retirement detection.
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ok_s) state_d = S_DECODE;
        else          state_d = S_FETCH;
      end
      S_DECODE: begin
        case (bus.op)
          2'b00: begin
            if (bus.funct[5]) state_d = S_EXECUTEI;
            else              state_d = S_EXECUTER;
          end
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (bus.funct[0]) state_d = S_MEMREAD;
        else              state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (mem_ok_s) state_d = S_MEMWB;
        else          state_d = S_MEMREAD;
      end
      S_MEMWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_MEMWRITE: begin
        // A store only retires on the edge that completes the write.
        if (mem_ok_s) begin
          state_d  = S_FETCH;
          retire_s = 1'b1;
        end else begin
          state_d  = S_MEMWRITE;
        end
      end
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_BRANCH: begin
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Retired counter update; wraps naturally at its width.
  always_comb begin
    if (retire_s) retired_d = retired_q + INSTR_CNT_W'(1);
    else          retired_d = retired_q;
  end

  // State and retired-count registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Moore output decode; unlisted outputs stay 0, unreachable codes give all 0.
  always_comb begin
    irwrite_s   = 1'b0;
    nextpc_s    = 1'b0;
    regw_s      = 1'b0;
    memw_s      = 1'b0;
    branch_s    = 1'b0;
    aluop_s     = 1'b0;
    adrsrc_s    = 1'b0;
    alusrca_s   = 2'b00;
    alusrcb_s   = 2'b00;
    resultsrc_s = 2'b00;
    case (state_q)
      S_FETCH: begin
        irwrite_s   = mem_ok_s;
        nextpc_s    = mem_ok_s;
        alusrca_s   = 2'b01;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
      end
      S_DECODE: begin
        alusrca_s   = 2'b01;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
      end
      S_MEMADR: begin
        alusrcb_s   = 2'b01;
      end
      S_MEMREAD: begin
        adrsrc_s    = 1'b1;
      end
      S_MEMWB: begin
        resultsrc_s = 2'b01;
        regw_s      = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc_s    = 1'b1;
        memw_s      = mem_ok_s;
      end
      S_EXECUTER: begin
        aluop_s     = 1'b1;
      end
      S_EXECUTEI: begin
        alusrcb_s   = 2'b01;
        aluop_s     = 1'b1;
      end
      S_ALUWB: begin
        regw_s      = 1'b1;
      end
      S_BRANCH: begin
        alusrca_s   = 2'b10;
        alusrcb_s   = 2'b01;
        resultsrc_s = 2'b10;
        branch_s    = 1'b1;
      end
      default: begin
        irwrite_s   = 1'b0;
      end
    endcase
  end

  assign bus.irwrite   = irwrite_s;
  assign bus.nextpc    = nextpc_s;
  assign bus.regw      = regw_s;
  assign bus.memw      = memw_s;
  assign bus.branch    = branch_s;
  assign bus.aluop     = aluop_s;
  assign bus.adrsrc    = adrsrc_s;
  assign bus.alusrca   = alusrca_s;
  assign bus.alusrcb   = alusrcb_s;
  assign bus.resultsrc = resultsrc_s;
  assign bus.state     = state_q;
  assign bus.retired   = retired_q;

endmodule

// File: tb/tb_arm_mc_mainfsm.sv
// Scoreboard bench for arm_mc_mainfsm. Two DUTs share stimulus: one with a
// 32-bit retired counter and one with a 4-bit counter to exercise wrap.
// The model walks each instruction as a list of phases; each cycle's expected
// outputs are queued and a monitor compares them on the falling edge.
module tb_arm_mc_mainfsm;

  localparam int K_DPR = 0, K_DPI = 1, K_LDR = 2, K_STR = 3, K_BR = 4, K_ILL = 5;

  typedef struct {
    int          st;
    logic [12:0] c;
    int unsigned cnt;
  } exp_t;

  logic clk;
  logic reset;
  exp_t exp_q[$];
  int unsigned model_cnt;
  int total;
  int bad;

  arm_mc_mainfsm_if #(.INSTR_CNT_W(32)) bif ();
  arm_mc_mainfsm_if #(.INSTR_CNT_W(4))  sif ();

  arm_mc_mainfsm #(.INSTR_CNT_W(32)) dut_big (.clk(clk), .reset(reset), .bus(bif.master));
  arm_mc_mainfsm #(.INSTR_CNT_W(4))  dut_small (.clk(clk), .reset(reset), .bus(sif.master));

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control vector for a phase:
  // {irwrite,nextpc,regw,memw,branch,aluop,adrsrc,alusrca,alusrcb,resultsrc}
  function automatic logic [12:0] exp_ctrl(input int ph, input logic rdy);
    logic ir, npc, rw, mw, br, ao, ad;
    logic [1:0] sa, sb, rs;
    ir = 1'b0; npc = 1'b0; rw = 1'b0; mw = 1'b0; br = 1'b0; ao = 1'b0; ad = 1'b0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00;
    case (ph)
      0: begin ir = rdy; npc = rdy; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      2: begin sb = 2'b01; end
      3: begin ad = 1'b1; end
      4: begin rs = 2'b01; rw = 1'b1; end
      5: begin ad = 1'b1; mw = rdy; end
      6: begin ao = 1'b1; end
      7: begin sb = 2'b01; ao = 1'b1; end
      8: begin rw = 1'b1; end
      9: begin sa = 2'b10; sb = 2'b01; rs = 2'b10; br = 1'b1; end
      default: begin ir = 1'b0; end
    endcase
    return {ir, npc, rw, mw, br, ao, ad, sa, sb, rs};
  endfunction

  // One clock of stimulus: drive inputs, queue the expected response, advance.
  task automatic cyc(input int st, input logic [12:0] c, input logic [1:0] op_v,
                     input logic [5:0] fn_v, input logic rdy, input logic rst_v);
    exp_t e;
    reset = rst_v;
    bif.op = op_v; sif.op = op_v;
    bif.funct = fn_v; sif.funct = fn_v;
    bif.mem_ready = rdy; sif.mem_ready = rdy;
    e.st = st; e.c = c; e.cnt = model_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Run one instruction; fw forces the wait count (-1 random); abort_idx
  // asserts reset in that phase instead of executing it (-1 none).
  task automatic run_instr(input int kind, input logic [5:0] fn_in, input int fw, input int abort_idx);
    int ph[$];
    logic [1:0] op_i;
    logic [5:0] fn_i;
    logic [1:0] op_d;
    logic [5:0] fn_d;
    logic rdy;
    int nw;
    fn_i = fn_in;
    case (kind)
      K_DPR: begin op_i = 2'b00; fn_i[5] = 1'b0; ph = '{0, 1, 6, 8}; end
      K_DPI: begin op_i = 2'b00; fn_i[5] = 1'b1; ph = '{0, 1, 7, 8}; end
      K_LDR: begin op_i = 2'b01; fn_i[0] = 1'b1; ph = '{0, 1, 2, 3, 4}; end
      K_STR: begin op_i = 2'b01; fn_i[0] = 1'b0; ph = '{0, 1, 2, 5}; end
      K_BR:  begin op_i = 2'b10; ph = '{0, 1, 9}; end
      default: begin op_i = 2'b11; ph = '{0, 1}; end
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      if (ph[i] == 1 || ph[i] == 2) begin
        op_d = op_i; fn_d = fn_i;
      end else begin
        op_d = 2'($urandom_range(0, 3)); fn_d = 6'($urandom_range(0, 63));
      end
      if (i == abort_idx) begin
        model_cnt = 0;
        cyc(0, exp_ctrl(0, 1'b1), op_d, fn_d, 1'b1, 1'b0);
        return;
      end
      nw = 0;
`ifdef ARM_MC_MEM_WAIT_EN
      if (ph[i] == 0 || ph[i] == 3 || ph[i] == 5) nw = (fw >= 0) ? fw : int'($urandom_range(0, 2));
      rdy = 1'b1;
`else
      rdy = 1'($urandom_range(0, 1));
`endif
      for (int w = 0; w < nw; w++) cyc(ph[i], exp_ctrl(ph[i], 1'b0), op_d, fn_d, 1'b0, 1'b1);
      cyc(ph[i], exp_ctrl(ph[i], 1'b1), op_d, fn_d, rdy, 1'b1);
    end
    if (kind != K_ILL) model_cnt = model_cnt + 1;
  endtask

  // Monitor: pop one expectation per falling edge and compare both DUTs.
  initial begin
    exp_t e;
    logic [12:0] act;
    logic [3:0] exp_small;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {bif.irwrite, bif.nextpc, bif.regw, bif.memw, bif.branch, bif.aluop,
               bif.adrsrc, bif.alusrca, bif.alusrcb, bif.resultsrc};
        total++;
        if (bif.state !== 4'(e.st) || act !== e.c) begin
          bad++;
          $display("FAIL ctrl t=%0t state=%0d ctrl=%b required state=%0d ctrl=%b",
                   $time, bif.state, act, e.st, e.c);
        end
        total++;
        if (bif.retired !== e.cnt) begin
          bad++;
          $display("FAIL retired32 t=%0t got=%0d required=%0d", $time, bif.retired, e.cnt);
        end
        exp_small = 4'(e.cnt % 16);
        total++;
        if (sif.retired !== exp_small || sif.state !== 4'(e.st)) begin
          bad++;
          $display("FAIL retired4 t=%0t got=%0d/state %0d required=%0d/state %0d",
                   $time, sif.retired, sif.state, exp_small, e.st);
        end
      end
    end
  end

  // Stimulus: reset, directed instructions, mid-load reset, random stream.
  initial begin
    int k;
    total = 0;
    bad = 0;
    model_cnt = 0;
    reset = 1'b0;
    bif.op = 2'b00; sif.op = 2'b00;
    bif.funct = 6'd0; sif.funct = 6'd0;
    bif.mem_ready = 1'b1; sif.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, exp_ctrl(0, 1'b1), 2'b00, 6'd0, 1'b1, 1'b0);
    cyc(0, exp_ctrl(0, 1'b1), 2'b00, 6'd0, 1'b1, 1'b0);
    run_instr(K_DPR, 6'b001000, 3, -1);
    run_instr(K_LDR, 6'b011001, -1, -1);
    run_instr(K_STR, 6'b011000, 2, -1);
    run_instr(K_BR, 6'b101010, -1, -1);
    run_instr(K_ILL, 6'b111111, -1, -1);
    run_instr(K_LDR, 6'b011001, 1, 3);
    run_instr(K_DPI, 6'b100100, -1, -1);
    for (int n = 0; n < 45; n++) begin
      k = int'($urandom_range(0, 5));
      run_instr(k, 6'($urandom_range(0, 63)), -1, -1);
    end
    run_instr(K_ILL, 6'b000000, 0, 1);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
